// File: rtl/fifo_deq_downsizer.sv
// Pops wide words from an upstream FIFO and enqueues them LSB-first as narrow beats.
// Optional LAST output is enabled with `define DOWNSIZER_LAST_EN.
module fifo_deq_downsizer #(
   parameter int IN_W  = 32,
   parameter int OUT_W = 8
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             CLR,
   input  logic             EMPTY_N,
   input  logic [IN_W-1:0]  D_IN,
   output logic             DEQ,
   input  logic             FULL_N,
   output logic             ENQ,
   output logic [OUT_W-1:0] D_OUT,
   output logic             BUSY
`ifdef DOWNSIZER_LAST_EN
   ,
   output logic             LAST
`endif
);

   localparam int RATIO = IN_W / OUT_W;
   localparam int IDX_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATIO - 1);

   if ((RATIO < 2) || (IN_W % OUT_W != 0)) begin : g_bad_cfg
      $error("fifo_deq_downsizer: IN_W must be a multiple (>=2) of OUT_W");
   end

   typedef enum logic {IDLE, SHIFT} state_e;

   state_e             state_q, state_d;
   logic [IN_W-1:0]    hold_q, hold_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [RATIO-1:0][OUT_W-1:0] beats;

   assign beats = hold_q;
   assign D_OUT = beats[idx_q];
   assign BUSY  = (state_q == SHIFT);

`ifdef DOWNSIZER_LAST_EN
   assign LAST = BUSY & (idx_q == LAST_IDX);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         hold_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         hold_q  <= hold_d;
         idx_q   <= idx_d;
      end
   end

   // Handshakes depend only on state and EMPTY_N/FULL_N, never on D_IN.
   always_comb begin
      state_d = state_q;
      hold_d  = hold_q;
      idx_d   = idx_q;
      DEQ     = 1'b0;
      ENQ     = 1'b0;
      if (RST) begin
         state_d = IDLE;
      end else if (CLR) begin
         state_d = IDLE;
         idx_d   = '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               DEQ = EMPTY_N;
               if (EMPTY_N) begin
                  hold_d  = D_IN;
                  idx_d   = '0;
                  state_d = SHIFT;
               end
            end
            SHIFT: begin
               ENQ = FULL_N;
               if (FULL_N) begin
                  if (idx_q != LAST_IDX) begin
                     idx_d = idx_q + 1'b1;
                  end else if (EMPTY_N) begin
                     DEQ    = 1'b1;
                     hold_d = D_IN;
                     idx_d  = '0;
                  end else begin
                     state_d = IDLE;
                     idx_d   = '0;
                  end
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_deq_downsizer.sv
// Scoreboard bench for fifo_deq_downsizer: upstream queue model feeds the DUT,
// expected beats are queued at push time and compared on every ENQ.
module tb_fifo_deq_downsizer;

   localparam int IN_W  = 32;
   localparam int OUT_W = 8;
   localparam int RATIO = IN_W / OUT_W;

   logic             clk;
   logic             RST, CLR, EMPTY_N, FULL_N;
   logic [IN_W-1:0]  D_IN;
   logic             DEQ, ENQ, BUSY;
   logic [OUT_W-1:0] D_OUT;
`ifdef DOWNSIZER_LAST_EN
   logic             LAST;
`endif

   fifo_deq_downsizer #(.IN_W(IN_W), .OUT_W(OUT_W)) dut (
      .CLK(clk), .RST(RST), .CLR(CLR), .EMPTY_N(EMPTY_N), .D_IN(D_IN),
      .DEQ(DEQ), .FULL_N(FULL_N), .ENQ(ENQ), .D_OUT(D_OUT), .BUSY(BUSY)
`ifdef DOWNSIZER_LAST_EN
      , .LAST(LAST)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   logic [IN_W-1:0]  up[$];
   logic [OUT_W-1:0] sb[$];
   int beats_left = 0;
   int n_enq = 0;
   int n_deq = 0;
   logic [OUT_W-1:0] coinc;
   logic             cyc_enq;
   logic [OUT_W-1:0] cyc_dout;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic push_word(input logic [IN_W-1:0] w);
      up.push_back(w);
      for (int i = 0; i < RATIO; i++) sb.push_back(w[i*OUT_W +: OUT_W]);
   endtask

   task automatic step(input logic fn, input logic clr);
      logic [OUT_W-1:0] exp;
      @(posedge clk);
      #1;
      EMPTY_N = (up.size() > 0);
      D_IN    = (up.size() > 0) ? up[0] : '0;
      FULL_N  = fn;
      CLR     = clr;
      #1;
      cyc_enq  = ENQ;
      cyc_dout = D_OUT;
      if (!EMPTY_N) chk("deq_guard", DEQ, 0);
      if (!FULL_N) chk("enq_guard", ENQ, 0);
      if (clr) begin
         chk("clr_deq", DEQ, 0);
         chk("clr_enq", ENQ, 0);
      end
`ifdef DOWNSIZER_LAST_EN
      chk("last", LAST, (beats_left == 1) ? 1 : 0);
`endif
      if (ENQ === 1'b1) begin
         n_enq++;
         if (sb.size() == 0) begin
            chk("sb_underrun", 1, 0);
         end else begin
            exp = sb.pop_front();
            chk("beat", D_OUT, exp);
         end
         if (beats_left > 0) beats_left--;
      end
      if (DEQ === 1'b1) begin
         n_deq++;
         if (up.size() > 0) void'(up.pop_front());
         if (ENQ === 1'b1) coinc = D_OUT;
         beats_left = RATIO;
      end
      if (clr) begin
         repeat (beats_left) void'(sb.pop_front());
         beats_left = 0;
      end
   endtask

   task automatic drain(input int max, input bit rnd, output int cyc);
      cyc = 0;
      while ((up.size() > 0 || sb.size() > 0) && cyc < max) begin
         step(rnd ? ($urandom_range(0, 3) != 0) : 1'b1, 1'b0);
         cyc++;
      end
      chk("drain_timeout", (cyc < max) ? 1 : 0, 1);
   endtask

   initial begin
      int cyc;
      RST = 1'b1; CLR = 1'b0; EMPTY_N = 1'b1; FULL_N = 1'b1;
      D_IN = 32'hDEADBEEF;
      repeat (2) begin
         @(posedge clk);
         #2;
         chk("rst_deq", DEQ, 0);
         chk("rst_enq", ENQ, 0);
         chk("rst_busy", BUSY, 0);
         chk("rst_dout", D_OUT, 0);
`ifdef DOWNSIZER_LAST_EN
         chk("rst_last", LAST, 0);
`endif
      end
      @(negedge clk);
      RST = 1'b0; EMPTY_N = 1'b0;
      @(posedge clk);
      #2;
      chk("post_rst_enq", ENQ, 0);
      chk("post_rst_busy", BUSY, 0);
      chk("post_rst_dout", D_OUT, 0);

      n_enq = 0; n_deq = 0;
      push_word(32'hA1B2C3D4);
      drain(50, 1'b0, cyc);
      chk("s2_cycles", cyc, 5);
      chk("s2_enq", n_enq, 4);
      chk("s2_deq", n_deq, 1);
      step(1'b1, 1'b0);
      chk("s2_idle_busy", BUSY, 0);
      chk("s2_idle_enq", ENQ, 0);

      n_enq = 0; n_deq = 0; coinc = '0;
      push_word(32'h11223344);
      push_word(32'h55667788);
      drain(50, 1'b0, cyc);
      chk("s3_cycles", cyc, 9);
      chk("s3_enq", n_enq, 8);
      chk("s3_deq", n_deq, 2);
      chk("s3_coinc", coinc, 8'h11);

      push_word(32'hA1B2C3D4);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("s4_beat0", cyc_dout, 8'hD4);
      repeat (3) begin
         step(1'b0, 1'b0);
         chk("s4_stall_enq", cyc_enq, 0);
         chk("s4_stall_dout", cyc_dout, 8'hC3);
      end
      step(1'b1, 1'b0);
      chk("s4_resume_enq", cyc_enq, 1);
      chk("s4_resume0", cyc_dout, 8'hC3);
      step(1'b1, 1'b0);
      chk("s4_resume1", cyc_dout, 8'hB2);
      drain(50, 1'b0, cyc);

      push_word(32'hCAFEF00D);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      chk("s5_beat0", cyc_dout, 8'h0D);
      push_word(32'h55AA1234);
      step(1'b1, 1'b1);
      step(1'b1, 1'b0);
      chk("s5_busy", BUSY, 0);
      chk("s5_enq", cyc_enq, 0);
      step(1'b1, 1'b0);
      chk("s5_fresh", cyc_dout, 8'h34);
      drain(50, 1'b0, cyc);

      for (int i = 0; i < 6; i++) push_word($urandom());
      drain(500, 1'b1, cyc);
      chk("sb_empty", sb.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

endmodule
